rx_fir_decim: RTL and testbench

// - Parametrised receive matched filter and decimator; next-generation Rx front end feeding demod/slicer.
// - Time-multiplexed single-MAC FIR: N_TAPS taps, runtime-loadable coefficients, integrated decimation by DECIM.
// - Adds valid/ready handshake, rounding, saturation, DC offset and a saturation flag.

---
 rtl/rx_filter_pkg.sv | 64 ++++++
 rtl/rx_mac_unit.sv | 48 ++++
 rtl/rx_fir_decim.sv | 190 +++++++++++++++++++
 tb/tb_rx_fir_decim.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_filter_pkg.sv
// Shared Rx/Tx filter definitions: FSM states, width helper, default taps, round/saturate.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rx_filter_pkg;

   // Filter sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      ROUND = 2'd2
   } fsm_state_t;

   // Working width of the round/saturate helper; accumulators up to this width are supported.
   localparam int RS_W = 64;

   typedef struct packed {
      logic signed [RS_W-1:0] y;
      logic                   sat;
   } rnd_sat_t;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Default tap table loaded at reset: unity gain on tap 0 (1.0 in Qx.frac_bits), all other taps zero,
   // so an unconfigured filter is a plain decimating pass-through.
   function automatic int default_coef(input int idx, input int frac_bits);
      return (idx == 0) ? (1 << frac_bits) : 0;
   endfunction

   // Round half up by frac_bits, add a DC offset, then clip to a signed out_w-bit range.
   // sat reports whether clipping happened.
   function automatic rnd_sat_t round_sat(input logic signed [RS_W-1:0] acc,
                                          input int frac_bits,
                                          input int offset,
                                          input int out_w);
      logic signed [RS_W-1:0] r;
      logic signed [RS_W-1:0] hi;
      logic signed [RS_W-1:0] lo;
      rnd_sat_t               res;
      r = acc;
      if (frac_bits > 0) r = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
      r  = r + RS_W'(offset);
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      res.y   = r;
      res.sat = 1'b0;
      if (r > hi) begin
         res.y   = hi;
         res.sat = 1'b1;
      end else if (r < lo) begin
         res.y   = lo;
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/rx_mac_unit.sv
// Signed multiply-accumulate with synchronous clear; product is registered before accumulation.
// Latency: a product issued with en_i appears in acc_o two edges later.
// Backpressure: none; the caller sequences en_i/clr_i and drains one extra cycle.
module rx_mac_unit #(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int ACC_W = 40
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [A_W-1:0]   a_i,
   input  logic signed [B_W-1:0]   b_i,
   output logic signed [ACC_W-1:0] acc_o
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0]   prod_q, prod_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   // Full-precision product; zero when idle so the drain cycle adds nothing.
   always_comb begin
      prod_d = '0;
      if (en_i) prod_d = P_W'(a_i) * P_W'(b_i);
   end

   // Accumulate the previous cycle's product, or restart from zero.
   always_comb begin
      acc_d = acc_q + ACC_W'(prod_q);
      if (clr_i) acc_d = '0;
   end

   // Pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/rx_fir_decim.sv
// Time-multiplexed single-MAC FIR with decimation, rounding, DC offset and saturation.
// Latency: out_valid pulses N_TAPS+2 edges after the triggering sample is accepted.
// Backpressure: in_ready drops for the whole MAC/ROUND run; non-triggering samples flow back-to-back.
module rx_fir_decim
   import rx_filter_pkg::*;
#(
   parameter int N_TAPS    = 97,
   parameter int DATA_W    = 16,
   parameter int COEFF_W   = 16,
   parameter int FRAC_BITS = 13,
   parameter int DECIM     = 6,
   parameter int ACC_W     = 40,
   parameter int OFFSET    = 2000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   input  logic signed [DATA_W-1:0]          in_data,
   output logic                              in_ready,
   input  logic                              coef_we,
   input  logic [clog2(N_TAPS)-1:0]          coef_addr,
   input  logic signed [COEFF_W-1:0]         coef_data,
   output logic                              out_valid,
   output logic signed [DATA_W-1:0]          out_data,
   output logic                              out_sat,
   output logic                              busy
);

   localparam int AW   = clog2(N_TAPS);
   localparam int PH_W = (DECIM > 1) ? clog2(DECIM) : 1;

   localparam logic [AW-1:0]   LAST_TAP   = AW'(N_TAPS - 1);
   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DECIM - 1);

   fsm_state_t state_q, state_d;

   logic signed [DATA_W-1:0]  smp_q  [N_TAPS];
   logic signed [COEFF_W-1:0] coef_q [N_TAPS];

   logic [AW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW-1:0]   k_q, k_d;
   logic [PH_W-1:0] ph_q, ph_d;
   logic            drain_q, drain_d;

   logic accept, trigger, coef_wr;
   logic mac_clr, mac_en, out_ld;

   logic signed [ACC_W-1:0] acc;
   rnd_sat_t                rnd;

   logic                     out_valid_q;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_sat_q, out_sat_d;

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign accept   = in_valid && in_ready;
   assign trigger  = accept && (ph_q == LAST_PHASE);
   assign coef_wr  = coef_we && (state_q == IDLE) && (int'(coef_addr) < N_TAPS);

   // Write pointer and decimation phase advance on every accepted sample.
   always_comb begin
      ptr_d = ptr_q;
      ph_d  = ph_q;
      if (accept) begin
         ptr_d = (ptr_q == LAST_TAP) ? '0 : ptr_q + 1'b1;
         ph_d  = (ph_q == LAST_PHASE) ? '0 : ph_q + 1'b1;
      end
   end

   // Sequencer: walk taps k=0..N_TAPS-1 newest sample first, drain the MAC pipe, then round.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      rd_d    = rd_q;
      drain_d = drain_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      out_ld  = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = MAC;
               k_d     = '0;
               rd_d    = ptr_q;
               mac_clr = 1'b1;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            k_d    = k_q + 1'b1;
            rd_d   = (rd_q == '0) ? LAST_TAP : rd_q - 1'b1;
            if (k_q == LAST_TAP) begin
               state_d = ROUND;
               drain_d = 1'b0;
            end
         end
         ROUND: begin
            // First ROUND cycle lets the last registered product land in the accumulator.
            if (!drain_q) begin
               drain_d = 1'b1;
            end else begin
               out_ld  = 1'b1;
               drain_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state registers; reset abandons any run in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         rd_q    <= '0;
         drain_q <= 1'b0;
         ptr_q   <= '0;
         ph_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         rd_q    <= rd_d;
         drain_q <= drain_d;
         ptr_q   <= ptr_d;
         ph_q    <= ph_d;
      end
   end

   // Circular sample history, cleared on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_TAPS; i++) smp_q[i] <= '0;
      end else if (accept) begin
         smp_q[ptr_q] <= in_data;
      end
   end

   // Tap registers: default table on reset, writable only while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_TAPS; i++) coef_q[i] <= COEFF_W'(default_coef(i, FRAC_BITS));
      end else if (coef_wr) begin
         coef_q[coef_addr] <= coef_data;
      end
   end

   rx_mac_unit #(
      .A_W   (DATA_W),
      .B_W   (COEFF_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr_i (mac_clr),
      .en_i  (mac_en),
      .a_i   (smp_q[rd_q]),
      .b_i   (coef_q[k_q]),
      .acc_o (acc)
   );

   // Round, offset and clip the finished accumulator.
   always_comb begin
      rnd        = round_sat(RS_W'(acc), FRAC_BITS, OFFSET, DATA_W);
      out_data_d = DATA_W'(rnd.y);
      out_sat_d  = rnd.sat;
   end

   // Output register: data and flag held between pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         out_valid_q <= out_ld;
         if (out_ld) begin
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_rx_fir_decim.sv
// Bench for rx_fir_decim: table vectors, hand-written corner sequences and randomized traffic.
// Two instances share stimulus: OFFSET=0 and OFFSET=2000.
// Expected outputs come from constant tables or a sum-of-products reference model.
module tb_rx_fir_decim;

   localparam int NT = 4;
   localparam int DC = 2;
   localparam int LAT = NT + 2;

   logic clk = 1'b0;
   logic reset;
   logic in_valid;
   logic signed [15:0] in_data;
   logic coef_we;
   logic [1:0] coef_addr;
   logic signed [15:0] coef_data;

   logic in_ready, out_valid, out_sat, busy;
   logic signed [15:0] out_data;
   logic in_ready_b, out_valid_b, out_sat_b, busy_b;
   logic signed [15:0] out_data_b;

   always #5 clk = ~clk;

   rx_fir_decim #(.N_TAPS(NT), .DATA_W(16), .COEFF_W(16), .FRAC_BITS(13),
                  .DECIM(DC), .ACC_W(40), .OFFSET(0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .busy(busy));

   rx_fir_decim #(.N_TAPS(NT), .DATA_W(16), .COEFF_W(16), .FRAC_BITS(13),
                  .DECIM(DC), .ACC_W(40), .OFFSET(2000)) dut_off (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_sat(out_sat_b), .busy(busy_b));

   int n_run = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct { int y0; bit s0; int y1; bit s1; int edge_n; } exp_t;
   exp_t expq[$];
   int   hist[$];
   int   mc[NT];

   typedef struct packed {
      int c0, c1, c2, c3;
      int xa, xb, nfirst, nout;
      int ya, yb, oa, ob;
      bit sa, sb;
   } vec_t;
   vec_t tv[5];

   task automatic check(input string nm, input longint act, input longint req);
      n_run++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   // Reference: floor((acc + 0.5 LSB) / 2^13), plus offset, clipped to int16.
   function automatic void ref_out(input longint acc, input int off, output int y, output bit s);
      longint t, q;
      t = acc + 4096;
      q = t / 8192;
      if (t < 0 && (t % 8192) != 0) q = q - 1;
      q = q + off;
      s = 1'b0;
      if (q > 32767) begin q = 32767; s = 1'b1; end
      else if (q < -32768) begin q = -32768; s = 1'b1; end
      y = int'(q);
   endfunction

   function automatic exp_t model_expect();
      exp_t   e;
      longint acc;
      int     n;
      n   = hist.size() - 1;
      acc = 0;
      for (int k = 0; k < NT; k++) begin
         if (n - k >= 0) acc += longint'(mc[k]) * longint'(hist[n - k]);
      end
      ref_out(acc, 0, e.y0, e.s0);
      ref_out(acc, 2000, e.y1, e.s1);
      e.edge_n = 0;
      return e;
   endfunction

   // One clock edge; outputs sampled 1 time unit later and checked against the expectation queue.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid || out_valid_b) begin
         check("offset instance out_valid alignment", out_valid_b, out_valid);
         if (expq.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected out_valid at cycle %0d: got 1, required 0", cyc);
         end else begin
            e = expq.pop_front();
            check("out_data", out_data, e.y0);
            check("out_sat", out_sat, e.s0);
            check("out_data offset", out_data_b, e.y1);
            check("out_sat offset", out_sat_b, e.s1);
            check("latency edges", cyc - e.edge_n, LAT);
            check("in_ready with out_valid", in_ready, 1);
         end
      end
   endtask

   function automatic void model_reset();
      expq.delete();
      hist.delete();
      for (int k = 0; k < NT; k++) mc[k] = (k == 0) ? 8192 : 0;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      coef_we = 1'b0;
      model_reset();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic write_coef(input int a, input int d, input bit apply);
      coef_we = 1'b1;
      coef_addr = 2'(a);
      coef_data = 16'(d);
      tick();
      coef_we = 1'b0;
      if (apply) mc[a] = d;
   endtask

   // Offer one sample (optionally with a coefficient write) and hold it until accepted.
   task automatic send_sample(input int v, input bit we, input int wa, input int wd, output bit trig);
      bit got, rdy;
      got = 1'b0;
      trig = 1'b0;
      in_valid = 1'b1;
      in_data = 16'(v);
      coef_we = we;
      coef_addr = 2'(wa);
      coef_data = 16'(wd);
      for (int g = 0; g < 64 && !got; g++) begin
         rdy = in_ready;
         tick();
         if (rdy) got = 1'b1;
      end
      in_valid = 1'b0;
      coef_we = 1'b0;
      if (!got) begin
         n_run++;
         n_fail++;
         $display("FAIL accept timeout: got in_ready=0, required 1");
      end else begin
         if (we) mc[wa] = wd;
         hist.push_back(v);
         trig = (hist.size() % DC) == 0;
      end
   endtask

   task automatic send_m(input int v, input bit we, input int wa, input int wd);
      bit   trig;
      exp_t e;
      send_sample(v, we, wa, wd, trig);
      if (trig) begin
         e = model_expect();
         e.edge_n = cyc;
         expq.push_back(e);
      end
   endtask

   task automatic wait_drain();
      for (int g = 0; g < 40 && (expq.size() != 0 || !in_ready); g++) tick();
      if (expq.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL drain timeout: got %0d outputs pending, required 0", expq.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit   trig;
      exp_t e;
      int   x, j, v, wsel;
      logic [15:0] r16;

      tv[0] = '{8192, 4096, 0, 0, 1000, 0, 1, 3, 500, 0, 2500, 2000, 1'b0, 1'b0};
      tv[1] = '{8192, 8192, 8192, 8192, 100, 100, 8, 4, 200, 400, 2200, 2400, 1'b0, 1'b0};
      tv[2] = '{16383, 16383, 16383, 16383, 32767, 32767, 4, 2, 32767, 32767, 32767, 32767, 1'b1, 1'b1};
      tv[3] = '{16383, 16383, 16383, 16383, -32768, -32768, 4, 2, -32768, -32768, -32768, -32768, 1'b1, 1'b1};
      tv[4] = '{4096, 0, 0, 0, 3, -3, 2, 2, 2, -1, 2002, 1999, 1'b0, 1'b0};

      in_data = '0;
      coef_addr = '0;
      coef_data = '0;
      do_reset();
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset out_sat", out_sat, 0);
      check("reset in_ready", in_ready, 1);
      check("reset busy", busy, 0);

      // Default taps after reset: unity on tap 0.
      send_m(7, 0, 0, 0);
      send_m(9, 0, 0, 0);
      wait_drain();

      // Table vectors.
      for (int t = 0; t < 5; t++) begin
         do_reset();
         write_coef(0, tv[t].c0, 1);
         write_coef(1, tv[t].c1, 1);
         write_coef(2, tv[t].c2, 1);
         write_coef(3, tv[t].c3, 1);
         for (int i = 0; i < 2 * tv[t].nout; i++) begin
            x = (i < tv[t].nfirst) ? tv[t].xa : tv[t].xb;
            send_sample(x, 0, 0, 0, trig);
            if (trig) begin
               j = i / 2;
               e.y0 = (j == 0) ? tv[t].ya : tv[t].yb;
               e.s0 = (j == 0) ? tv[t].sa : tv[t].sb;
               e.y1 = (j == 0) ? tv[t].oa : tv[t].ob;
               e.s1 = e.s0;
               e.edge_n = cyc;
               expq.push_back(e);
            end
         end
         wait_drain();
      end

      // Busy-time write ignored, held sample not lost, idle write and trigger-cycle write applied.
      do_reset();
      write_coef(0, 8192, 1);
      write_coef(1, 8192, 1);
      send_m(100, 0, 0, 0);
      send_m(200, 0, 0, 0);
      check("busy after trigger", busy, 1);
      check("in_ready low after trigger", in_ready, 0);
      write_coef(0, 0, 0);
      send_m(300, 0, 0, 0);
      send_m(400, 0, 0, 0);
      wait_drain();
      write_coef(0, 4096, 1);
      send_m(10, 0, 0, 0);
      send_m(20, 0, 0, 0);
      send_m(30, 0, 0, 0);
      send_m(40, 1, 1, 0);
      wait_drain();

      // Reset in the middle of a MAC run.
      do_reset();
      write_coef(0, 8192, 1);
      write_coef(1, 8192, 1);
      send_m(1000, 0, 0, 0);
      send_sample(1000, 0, 0, 0, trig);
      tick();
      tick();
      reset = 1'b1;
      model_reset();
      tick();
      reset = 1'b0;
      check("mid-MAC reset out_valid", out_valid, 0);
      check("mid-MAC reset out_data", out_data, 0);
      check("mid-MAC reset in_ready", in_ready, 1);
      check("mid-MAC reset busy", busy, 0);
      for (int i = 0; i < 10; i++) tick();
      for (int k = 0; k < NT; k++) write_coef(k, 8192, 1);
      send_m(0, 0, 0, 0);
      send_m(0, 0, 0, 0);
      wait_drain();

      // Randomized traffic against the reference model.
      do_reset();
      for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 32767)) - 16384, 1);
      for (int i = 0; i < 80; i++) begin
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
         if ($urandom_range(0, 3) == 0) begin
            r16 = 16'($urandom);
            v = int'($signed(r16));
         end else begin
            v = int'($urandom_range(0, 4000)) - 2000;
         end
         wsel = int'($urandom_range(0, 7));
         if (wsel == 0)
            send_m(v, 1, int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 32767)) - 16384);
         else
            send_m(v, 0, 0, 0);
         if (wsel == 1 && (hist.size() % DC) != 0)
            write_coef(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 32767)) - 16384, 1);
      end
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
